// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   req    : read request (one cycle per request)
//   addr   : request address
//   rvalid : read data valid, one pulse per request
//   rdata  : instruction word, valid with rvalid
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input rvalid, input rdata);
   modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register. Owns the PC, keeps at
// most one imem read outstanding, and discards a response that was in flight
// when a redirect arrived.
//   clk, reset        : clock, synchronous active-high reset
//   stall             : IF/ID not accepting; presented instruction is held
//   redirect          : flush and redirect fetch to redirect_pc (word aligned)
//   imem              : instruction memory bus (master side)
//   instr_out, PC_out : presented instruction and its PC (registered)
//   valid_out         : instr_out/PC_out hold a real fetched instruction
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect,
   input  logic [31:0]         redirect_pc,
   fetch_unit_if.master        imem,
   output logic [31:0]         instr_out,
   output logic [31:0]         PC_out,
   output logic                valid_out
);

   localparam int unsigned XLEN = 32;

   typedef enum logic {FETCH = 1'b0, WAIT = 1'b1} state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic              kill;
   logic [XLEN-1:0]   redirect_aligned;

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

   // Issue only when the output slot is (or is about to be) free, so a
   // response always has somewhere to land.
   assign imem.req  = (state == FETCH) && !reset && !redirect && (!valid_out || !stall);
   assign imem.addr = pc;

   // Fetch control, PC and IF/ID output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         state     <= FETCH;
         kill      <= 1'b0;
         instr_out <= NOP;
         PC_out    <= '0;
         valid_out <= 1'b0;
      end else begin
         // Consume empties the slot; a capture below overrides this.
         if (valid_out && !stall) begin
            valid_out <= 1'b0;
            instr_out <= NOP;
         end

         case (state)
            FETCH: begin
               if (imem.req) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  if (imem.rvalid) begin
                     kill  <= 1'b0;
                     state <= FETCH;
                  end else begin
                     // Response still in flight: drop it when it arrives.
                     kill <= 1'b1;
                  end
               end else if (imem.rvalid && kill) begin
                  kill  <= 1'b0;
                  state <= FETCH;
               end else if (imem.rvalid) begin
                  instr_out <= imem.rdata;
                  PC_out    <= pc;
                  valid_out <= 1'b1;
                  pc        <= XLEN'(pc + XLEN'(4));
                  state     <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase

         // Redirect flushes the slot and wins over capture and consume.
         if (redirect) begin
            pc        <= redirect_aligned;
            valid_out <= 1'b0;
            instr_out <= NOP;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized stall/redirect/reset/latency checked every cycle against a
// transaction-level model (one outstanding read, output slot, expected PC).
module tb_fetch_unit;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr_out;
   logic [31:0] PC_out;
   logic        valid_out;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(32'h0), .NOP(NOP_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem),
      .instr_out   (instr_out),
      .PC_out      (PC_out),
      .valid_out   (valid_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state
   bit          m_init = 0;
   logic [31:0] m_pc;
   bit          m_out;          // a read is outstanding
   bit          m_killed;       // outstanding read must be discarded
   logic [31:0] m_req_addr;
   int          m_resp_cyc;
   bit          m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pcout;
   bit          exp_req;
   int          cyc = 0;
   int          lat = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h0060_0113;
         32'h0000_0008: return 32'h00A0_0193;
         default: begin
            if (a[6:2] == 5'h1f) return 32'h0;
            return {a[15:0] ^ 16'h5a5a, a[31:16]} ^ 32'h1357_9bdf;
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle's inputs, then compare the DUT against the model.
   task automatic cb(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
      @(negedge clk);
      reset       = rst;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem.rvalid = m_init && m_out && (cyc == m_resp_cyc);
      imem.rdata  = imem.rvalid ? mem_word(m_req_addr) : $urandom;
      exp_req     = m_init && !rst && !m_out && !rd && (!m_valid || !st);
      #1;
      if (m_init) begin
         chk("imem_req", 32'(imem.req), 32'(exp_req));
         chk("imem_addr", imem.addr, m_pc);
         chk("valid_out", 32'(valid_out), 32'(m_valid));
         chk("instr_out", instr_out, m_instr);
         chk("PC_out", PC_out, m_pcout);
      end
   endtask

   // Advance the clock and update the model from this cycle's inputs.
   task automatic ce();
      @(posedge clk);
      if (reset) begin
         m_init   = 1;
         m_pc     = 32'h0;
         m_out    = 0;
         m_killed = 0;
         m_valid  = 0;
         m_instr  = NOP_W;
         m_pcout  = 32'h0;
      end else if (m_init) begin
         if (m_valid && !stall) begin
            m_valid = 0;
            m_instr = NOP_W;
         end
         if (imem.rvalid) begin
            m_out = 0;
            if (!m_killed && !redirect) begin
               m_valid = 1;
               m_instr = imem.rdata;
               m_pcout = m_req_addr;
               m_pc    = m_req_addr + 32'd4;
            end
            m_killed = 0;
         end
         if (exp_req) begin
            m_out      = 1;
            m_killed   = 0;
            m_req_addr = m_pc;
            m_resp_cyc = cyc + lat;
         end
         if (redirect) begin
            m_pc    = redirect_pc & ~32'h3;
            m_valid = 0;
            m_instr = NOP_W;
            if (m_out) m_killed = 1;
         end
      end
      cyc++;
   endtask

   initial begin
      reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
      imem.rvalid = 0; imem.rdata = 0;

      // Reset
      cb(1, 0, 0, 0); ce();
      cb(1, 0, 0, 0);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_instr", instr_out, 32'h13);
      chk("rst_pcout", PC_out, 32'h0);
      chk("rst_req", 32'(imem.req), 32'h0);
      ce();

      // Back-to-back fetches with L=1
      lat = 1;
      cb(0, 0, 0, 0); chk("c0_req", 32'(imem.req), 1); chk("c0_addr", imem.addr, 0); ce();
      cb(0, 0, 0, 0); chk("c1_req", 32'(imem.req), 0); ce();
      cb(0, 0, 0, 0);
      chk("c2_valid", 32'(valid_out), 1); chk("c2_instr", instr_out, 32'h0050_0093);
      chk("c2_pcout", PC_out, 0); chk("c2_addr", imem.addr, 4); ce();
      cb(0, 0, 0, 0); ce();
      cb(0, 0, 0, 0);
      chk("c4_instr", instr_out, 32'h0060_0113); chk("c4_pcout", PC_out, 4);
      chk("c4_addr", imem.addr, 8); ce();
      cb(0, 0, 0, 0); ce();

      // Stall holds outputs and blocks issue
      for (int i = 0; i < 4; i++) begin
         cb(0, 1, 0, 0);
         chk("stall_valid", 32'(valid_out), 1); chk("stall_instr", instr_out, 32'h00A0_0193);
         chk("stall_pcout", PC_out, 8); chk("stall_req", 32'(imem.req), 0);
         ce();
      end
      lat = 3;
      cb(0, 0, 0, 0); chk("unstall_req", 32'(imem.req), 1); chk("unstall_addr", imem.addr, 12); ce();

      // Redirect during WAIT, late response killed
      cb(0, 0, 1, 32'h100); chk("redir_req", 32'(imem.req), 0); ce();
      cb(0, 0, 0, 0); ce();
      cb(0, 0, 0, 0); chk("kill_rvalid", 32'(imem.rvalid), 1); ce();
      lat = 1;
      cb(0, 0, 0, 0);
      chk("kill_valid", 32'(valid_out), 0); chk("redir_addr", imem.addr, 32'h100);
      chk("redir_req2", 32'(imem.req), 1); ce();
      cb(0, 0, 0, 0); ce();
      cb(0, 0, 0, 0); chk("redir_pcout", PC_out, 32'h100); chk("redir_valid", 32'(valid_out), 1); ce();

      // Redirect coinciding with rvalid while stalled
      cb(0, 1, 1, 32'h203); chk("rr_rvalid", 32'(imem.rvalid), 1); ce();
      cb(0, 0, 0, 0);
      chk("rr_valid", 32'(valid_out), 0); chk("rr_instr", instr_out, 32'h13);
      chk("rr_addr", imem.addr, 32'h200); ce();

      // PC wrap
      cb(0, 0, 1, 32'hFFFF_FFFC); ce();
      cb(0, 0, 0, 0); chk("wrap_addr", imem.addr, 32'hFFFF_FFFC); ce();
      cb(0, 0, 0, 0); ce();
      cb(0, 0, 0, 0);
      chk("wrap_pcout", PC_out, 32'hFFFF_FFFC); chk("wrap_next", imem.addr, 32'h0);
      ce();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
         lat = 1 + int'($urandom % 4);
         cb(($urandom % 400) == 0, ($urandom % 10) < 3, ($urandom % 20) == 0, rpc);
         ce();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
